// File: rtl/data_mux_pkg.sv
// ---------------------------------------------------------------------------
// data_mux_pkg
// Shared types and default patterns for the link data mux and its receive-side
// demux. Imported by the demux top, its word classifier and future monitors.
//   word_class_t     : classification of one link word (first match wins)
//   rx_state_t       : receive framing state
//   DEFAULT_*        : register defaults used by the mux for idle and header words
//   isIdleClass()    : true for either flavour of idle word
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package data_mux_pkg;

   typedef enum logic [2:0] {
      IDLE_BX0,
      IDLE,
      HDR_BX0,
      HDR,
      DATA
   } word_class_t;

   typedef enum logic [1:0] {
      HUNT,
      LOCKED_IDLE,
      PAYLOAD
   } rx_state_t;

   localparam logic [31:0] DEFAULT_IDLE_WORD     = 32'hACCC_CCCC;
   localparam logic [31:0] DEFAULT_IDLE_WORD_BX0 = 32'h9CCC_CCCC;
   localparam logic [31:0] DEFAULT_HEADER        = 32'hA000_0000;
   localparam logic [31:0] DEFAULT_HEADER_BX0    = 32'h9000_0000;
   localparam logic [31:0] DEFAULT_HEADER_MASK   = 32'hF000_0000;

   function automatic logic isIdleClass(input word_class_t cls);
      return (cls == IDLE) || (cls == IDLE_BX0);
   endfunction

endpackage

// File: rtl/data_demux_rx_if.sv
// ---------------------------------------------------------------------------
// data_demux_rx_if
// Groups the framed input stream and the payload output stream of the demux.
//   axis_in_*  : framed link stream into the demux (tdata, tvalid, tready)
//   axis_out_* : payload stream out of the demux (tdata, tvalid, tready,
//                tlast, tuser = packet introduced by a BX0 header)
// Modports:
//   slave  : the demux's view (consumes axis_in, produces axis_out)
//   master : the surrounding logic's view
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface data_demux_rx_if #(
   parameter int DATA_WIDTH = 32
);

   logic [DATA_WIDTH-1:0] axis_in_tdata;
   logic                  axis_in_tvalid;
   logic                  axis_in_tready;

   logic [DATA_WIDTH-1:0] axis_out_tdata;
   logic                  axis_out_tvalid;
   logic                  axis_out_tready;
   logic                  axis_out_tlast;
   logic                  axis_out_tuser;

   modport slave (
      input  axis_in_tdata,
      input  axis_in_tvalid,
      output axis_in_tready,
      output axis_out_tdata,
      output axis_out_tvalid,
      input  axis_out_tready,
      output axis_out_tlast,
      output axis_out_tuser
   );

   modport master (
      output axis_in_tdata,
      output axis_in_tvalid,
      input  axis_in_tready,
      input  axis_out_tdata,
      input  axis_out_tvalid,
      output axis_out_tready,
      input  axis_out_tlast,
      input  axis_out_tuser
   );

endinterface

// File: rtl/data_word_classifier.sv
// ---------------------------------------------------------------------------
// data_word_classifier
// Purely combinational classification of one link word against the idle and
// header patterns. Exact compare for idles, masked compare for headers; the
// BX0 flavour of each is tested before the plain one, first match wins.
// Ports:
//   i_word          : word to classify (already bit-order corrected)
//   i_idle_word     : idle pattern
//   i_idle_word_BX0 : BX0 idle pattern
//   i_header_mask   : bits of the word that take part in header compares
//   i_header        : header pattern
//   i_header_BX0    : BX0 header pattern
//   o_class         : resulting word class
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module data_word_classifier
   import data_mux_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] i_word,
   input  logic [DATA_WIDTH-1:0] i_idle_word,
   input  logic [DATA_WIDTH-1:0] i_idle_word_BX0,
   input  logic [DATA_WIDTH-1:0] i_header_mask,
   input  logic [DATA_WIDTH-1:0] i_header,
   input  logic [DATA_WIDTH-1:0] i_header_BX0,
   output word_class_t           o_class
);

   logic [DATA_WIDTH-1:0] w_masked;

   assign w_masked = i_word & i_header_mask;

   always_comb begin
      o_class = DATA;
      if (i_word == i_idle_word_BX0) begin
         o_class = IDLE_BX0;
      end else if (i_word == i_idle_word) begin
         o_class = IDLE;
      end else if (w_masked == (i_header_BX0 & i_header_mask)) begin
         o_class = HDR_BX0;
      end else if (w_masked == (i_header & i_header_mask)) begin
         o_class = HDR;
      end
   end

endmodule

// File: rtl/data_demux_rx.sv
// ---------------------------------------------------------------------------
// data_demux_rx
// Receive side of the link data mux. Locks onto a run of idle words, strips
// idles and headers, and forwards fixed-length payloads with tlast and a BX0
// tuser flag. A single output register gives one cycle of latency.
// Ports:
//   clk, aresetn     : clock, asynchronous active-low reset
//   bus (slave)      : framed input stream and payload output stream
//   idle_word(_BX0)  : idle patterns
//   header_mask, header, header_BX0 : header patterns
//   packet_len       : payload words per packet (0 behaves as 1)
//   lock_count       : consecutive idles needed to lock (0 behaves as 1)
//   fc_linkReset     : synchronous relock request, highest priority
//   locked           : framing state is not HUNT
//   bx0_pulse        : one-cycle pulse per accepted BX0 idle/header
//   packet_count     : completed packets, wraps
//   error_count      : framing errors, saturates
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module data_demux_rx
   import data_mux_pkg::*;
#(
   parameter int DATA_WIDTH         = 32,
   parameter int INPUT_REVERSE_BITS = 1,
   parameter int LOCK_WIDTH         = 16
) (
   input  logic                  clk,
   input  logic                  aresetn,
   data_demux_rx_if.slave        bus,
   input  logic [DATA_WIDTH-1:0] idle_word,
   input  logic [DATA_WIDTH-1:0] idle_word_BX0,
   input  logic [DATA_WIDTH-1:0] header_mask,
   input  logic [DATA_WIDTH-1:0] header,
   input  logic [DATA_WIDTH-1:0] header_BX0,
   input  logic [7:0]            packet_len,
   input  logic [LOCK_WIDTH-1:0] lock_count,
   input  logic                  fc_linkReset,
   output logic                  locked,
   output logic                  bx0_pulse,
   output logic [31:0]           packet_count,
   output logic [15:0]           error_count
);

   rx_state_t             r_state;
   logic [LOCK_WIDTH-1:0] r_run;
   logic [7:0]            r_remaining;
   logic                  r_bx0_flag;
   logic [DATA_WIDTH-1:0] r_out_tdata;
   logic                  r_out_tvalid;
   logic                  r_out_tlast;
   logic                  r_out_tuser;
   logic                  r_bx0_pulse;
   logic [31:0]           r_packet_count;
   logic [15:0]           r_error_count;

   rx_state_t             w_state_nxt;
   logic [LOCK_WIDTH-1:0] w_run_nxt;
   logic [LOCK_WIDTH-1:0] w_run_inc;
   logic [LOCK_WIDTH-1:0] w_lock_target;
   logic [7:0]            w_remaining_nxt;
   logic [7:0]            w_len_eff;
   logic                  w_bx0_flag_nxt;
   logic [DATA_WIDTH-1:0] w_word;
   word_class_t           w_class;
   logic                  w_accept;
   logic                  w_fwd;
   logic                  w_fwd_last;
   logic                  w_pkt_done;
   logic                  w_err;
   logic                  w_bx0_evt;

   // Undo the mux's output bit reversal so classification and forwarded
   // payload see words in their natural bit order.
   always_comb begin
      w_word = bus.axis_in_tdata;
      if (INPUT_REVERSE_BITS != 0) begin
         for (int i = 0; i < DATA_WIDTH; i++) begin
            w_word[i] = bus.axis_in_tdata[DATA_WIDTH-1-i];
         end
      end
   end

   data_word_classifier #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_classifier (
      .i_word          (w_word),
      .i_idle_word     (idle_word),
      .i_idle_word_BX0 (idle_word_BX0),
      .i_header_mask   (header_mask),
      .i_header        (header),
      .i_header_BX0    (header_BX0),
      .o_class         (w_class)
   );

   // The output register is the only buffer: accept a new word whenever it is
   // empty or draining this cycle. Held low while reset is asserted.
   assign bus.axis_in_tready = aresetn & (~r_out_tvalid | bus.axis_out_tready);
   assign w_accept           = bus.axis_in_tvalid & bus.axis_in_tready;

   assign w_lock_target = (lock_count == '0) ? LOCK_WIDTH'(1) : lock_count;
   assign w_len_eff     = (packet_len == 8'd0) ? 8'd1 : packet_len;
   assign w_run_inc     = (r_run == '1) ? r_run : r_run + LOCK_WIDTH'(1);

   // Next-state and event decode. A link reset overrides everything, including
   // a word accepted in the same cycle, which is simply dropped.
   always_comb begin
      w_state_nxt     = r_state;
      w_run_nxt       = r_run;
      w_remaining_nxt = r_remaining;
      w_bx0_flag_nxt  = r_bx0_flag;
      w_fwd           = 1'b0;
      w_fwd_last      = 1'b0;
      w_pkt_done      = 1'b0;
      w_err           = 1'b0;
      w_bx0_evt       = 1'b0;
      if (fc_linkReset) begin
         w_state_nxt = HUNT;
         w_run_nxt   = '0;
         w_err       = (r_state == PAYLOAD);
      end else if (w_accept) begin
         case (r_state)
            HUNT: begin
               w_bx0_evt = (w_class == IDLE_BX0);
               if (isIdleClass(w_class)) begin
                  if (w_run_inc >= w_lock_target) begin
                     w_state_nxt = LOCKED_IDLE;
                     w_run_nxt   = '0;
                  end else begin
                     w_run_nxt = w_run_inc;
                  end
               end else begin
                  w_run_nxt = '0;
               end
            end
            LOCKED_IDLE: begin
               case (w_class)
                  IDLE_BX0: begin
                     w_bx0_evt = 1'b1;
                  end
                  IDLE: begin
                     w_state_nxt = LOCKED_IDLE;
                  end
                  HDR_BX0, HDR: begin
                     w_state_nxt     = PAYLOAD;
                     w_remaining_nxt = w_len_eff;
                     w_bx0_flag_nxt  = (w_class == HDR_BX0);
                     w_bx0_evt       = (w_class == HDR_BX0);
                  end
                  default: begin
                     w_err       = 1'b1;
                     w_state_nxt = HUNT;
                     w_run_nxt   = '0;
                  end
               endcase
            end
            PAYLOAD: begin
               // Payload words are never classified; they may alias idles or headers.
               w_fwd           = 1'b1;
               w_fwd_last      = (r_remaining == 8'd1);
               w_remaining_nxt = r_remaining - 8'd1;
               if (w_fwd_last) begin
                  w_pkt_done  = 1'b1;
                  w_state_nxt = LOCKED_IDLE;
               end
            end
            default: begin
               w_state_nxt = HUNT;
               w_run_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_state     <= HUNT;
         r_run       <= '0;
         r_remaining <= 8'd0;
         r_bx0_flag  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_run       <= w_run_nxt;
         r_remaining <= w_remaining_nxt;
         r_bx0_flag  <= w_bx0_flag_nxt;
      end
   end

   // Output beat register: a loaded beat stays untouched until the consumer
   // takes it; loading only happens when the register is free (see tready).
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_out_tdata  <= '0;
         r_out_tvalid <= 1'b0;
         r_out_tlast  <= 1'b0;
         r_out_tuser  <= 1'b0;
      end else if (w_fwd) begin
         r_out_tdata  <= w_word;
         r_out_tvalid <= 1'b1;
         r_out_tlast  <= w_fwd_last;
         r_out_tuser  <= r_bx0_flag;
      end else if (bus.axis_out_tready) begin
         r_out_tvalid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_bx0_pulse    <= 1'b0;
         r_packet_count <= 32'd0;
         r_error_count  <= 16'd0;
      end else begin
         r_bx0_pulse <= w_bx0_evt;
         if (w_pkt_done) begin
            r_packet_count <= r_packet_count + 32'd1;
         end
         if (w_err && (r_error_count != 16'hFFFF)) begin
            r_error_count <= r_error_count + 16'd1;
         end
      end
   end

   assign bus.axis_out_tdata  = r_out_tdata;
   assign bus.axis_out_tvalid = r_out_tvalid;
   assign bus.axis_out_tlast  = r_out_tlast;
   assign bus.axis_out_tuser  = r_out_tuser;
   assign locked              = (r_state != HUNT);
   assign bx0_pulse           = r_bx0_pulse;
   assign packet_count        = r_packet_count;
   assign error_count         = r_error_count;

endmodule
